// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl -- serial-to-parallel receive controller.
//
// Frames a serial bit stream (MSB first) into a DW-bit word using a
// shift-left register. The finished word is held behind a valid/ready
// handshake.
//
// Optional feature macro: SIPO_RX_CTRL_PARITY_EN
//   When defined, each frame carries one trailing even-parity bit. That bit
//   is checked but is not shifted into the word.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   sof       start-of-frame strobe
//   bit_vld   qualifies bit_dat
//   bit_dat   serial data bit
//   word_rdy  consumer ready
//   clr_ovr   clears the sticky overrun flag
//   word      assembled word; bit 0 is the last data bit received
//   word_vld  word available (HOLD)
//   busy      high in SHIFT or HOLD
//   ovr       sticky overrun flag
//   par_err   parity error, meaningful while word_vld=1
module sipo_rx_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sof,
  input  logic          bit_vld,
  input  logic          bit_dat,
  input  logic          word_rdy,
  input  logic          clr_ovr,
  output logic [DW-1:0] word,
  output logic          word_vld,
  output logic          busy,
  output logic          ovr,
  output logic          par_err
);

`ifdef SIPO_RX_CTRL_PARITY_EN
  localparam int NBITS = DW + 1;
`else
  localparam int NBITS = DW;
`endif
  // Sized for NBITS so the parity build can still count to DW+1.
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST_M1 = CW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t        r_state;
  logic [DW-1:0] r_sr;
  logic [CW-1:0] r_cnt;
  logic          r_vld;
  logic          r_busy;
  logic          r_ovr;

  logic w_start;
  logic w_ovr_set;
  logic w_shift_en;
  logic w_last;

  // A sof is accepted in IDLE and SHIFT (abort). In HOLD it is accepted only
  // when the held word transfers on the same edge; otherwise it is an overrun.
  assign w_start   = sof && (r_state != HOLD || word_rdy);
  assign w_ovr_set = sof && r_state == HOLD && !word_rdy;
  assign w_last    = (r_cnt == LAST_M1);

`ifdef SIPO_RX_CTRL_PARITY_EN
  localparam logic [CW-1:0] CNT_DW = CW'(DW);
  logic r_par;
  logic r_perr;

  // The bit that arrives with count == DW is the parity bit and stays out of word.
  assign w_shift_en = (r_cnt != CNT_DW);

  // r_par is the running XOR of every accepted bit, including the parity bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else if (w_start) begin
      r_par <= bit_vld & bit_dat;
    end else if (r_state == SHIFT && bit_vld) begin
      r_par <= r_par ^ bit_dat;
      if (w_last) r_perr <= r_par ^ bit_dat;
    end
  end

  assign par_err = r_perr;
`else
  assign w_shift_en = 1'b1;
  assign par_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      // If set and clear arrive together, set wins.
      if (w_ovr_set)    r_ovr <= 1'b1;
      else if (clr_ovr) r_ovr <= 1'b0;

      if (w_start) begin
        // A bit that arrives together with sof is bit 0 of the new frame.
        r_state <= SHIFT;
        r_busy  <= 1'b1;
        r_vld   <= 1'b0;
        r_sr    <= bit_vld ? {{(DW-1){1'b0}}, bit_dat} : '0;
        r_cnt   <= bit_vld ? CW'(1) : '0;
      end else begin
        case (r_state)
          SHIFT: begin
            if (bit_vld) begin
              if (w_shift_en) r_sr <= {r_sr[DW-2:0], bit_dat};
              r_cnt <= r_cnt + 1'b1;
              if (w_last) begin
                r_state <= HOLD;
                r_vld   <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (word_rdy) begin
              r_state <= IDLE;
              r_vld   <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
          IDLE:    ;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign word     = r_sr;
  assign word_vld = r_vld;
  assign busy     = r_busy;
  assign ovr      = r_ovr;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Testbench for sipo_rx_ctrl (DW=8). The bench has three parts:
//   - a table of per-cycle vectors,
//   - hand-written multi-cycle sequences,
//   - randomized frames checked against a frame-level model.
// When SIPO_RX_CTRL_PARITY_EN is defined, frames carry a parity bit.
module tb_sipo_rx_ctrl;
  localparam int DW = 8;
`ifdef SIPO_RX_CTRL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, sof, bit_vld, bit_dat, word_rdy, clr_ovr;
  logic [DW-1:0] word;
  logic          word_vld, busy, ovr, par_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sipo_rx_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .sof(sof), .bit_vld(bit_vld), .bit_dat(bit_dat),
    .word_rdy(word_rdy), .clr_ovr(clr_ovr), .word(word), .word_vld(word_vld),
    .busy(busy), .ovr(ovr), .par_err(par_err)
  );

  typedef struct {
    logic          sof, bv, bd, rdy, clr;
    logic [DW-1:0] e_word;
    logic          e_vld, e_busy, e_ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t r(input logic s, bv, bd, rdy, clr,
                             input logic [DW-1:0] w, input logic v, b, o);
    vec_t x;
    x.sof = s; x.bv = bv; x.bd = bd; x.rdy = rdy; x.clr = clr;
    x.e_word = w; x.e_vld = v; x.e_busy = b; x.e_ovr = o;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Sends sof plus the DW data bits, MSB first. Between bits it inserts
  // `gap` idle cycles, and it appends the parity bit in the parity build.
  // word_vld must stay low until the final accepted bit; busy must stay high.
  task automatic send_frame(input logic [DW-1:0] d, input int gap, input logic pbit);
    int nb;
    nb = PAR ? DW + 1 : DW;
    for (int i = 0; i < nb; i++) begin
      if (i != 0) begin
        repeat (gap) begin
          sof = 1'b0; bit_vld = 1'b0;
          tick();
          chk("gap_busy", 32'(busy), 32'd1);
        end
      end
      sof     = (i == 0);
      bit_vld = 1'b1;
      bit_dat = (i < DW) ? d[DW-1-i] : pbit;
      tick();
      chk("frm_busy", 32'(busy), 32'd1);
      chk("frm_vld", 32'(word_vld), 32'(i == nb - 1));
    end
    sof = 1'b0; bit_vld = 1'b0; bit_dat = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d, d2;
    logic          flip, exp_ovr;
    int            k;

    rst = 1'b1; sof = 0; bit_vld = 0; bit_dat = 0; word_rdy = 0; clr_ovr = 0;
    repeat (2) tick();
    chk("rst_word", 32'(word), 32'd0);
    chk("rst_vld", 32'(word_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_par", 32'(par_err), 32'd0);
    @(negedge clk); rst = 1'b0;

    // ---- vector table: basic frame 0xB2, then overrun and clear on 0x5A ----
    tbl.push_back(r(0,0,0,1,0, 8'h00, 0,0,0));
    d = 8'hB2;
    for (int i = DW-1; i >= 0; i--)
      tbl.push_back(r(i == DW-1, 1, d[i], 1, 0, d >> i, (i == 0) && !PAR, 1, 0));
    if (PAR) tbl.push_back(r(0,1,1'b0,1,0, d, 1,1,0));
    tbl.push_back(r(0,0,0,1,0, d, 0,0,0));     // transferred after one valid cycle
    tbl.push_back(r(0,1,1,1,0, d, 0,0,0));     // bit_vld without sof ignored
    d = 8'h5A;
    for (int i = DW-1; i >= 0; i--)
      tbl.push_back(r(i == DW-1, 1, d[i], 0, 0, d >> i, (i == 0) && !PAR, 1, 0));
    if (PAR) tbl.push_back(r(0,1,1'b0,0,0, d, 1,1,0));
    tbl.push_back(r(0,1,1,0,0, d, 1,1,0));     // bit_vld ignored in HOLD
    tbl.push_back(r(1,0,0,0,0, d, 1,1,1));     // overrun
    tbl.push_back(r(1,0,0,0,1, d, 1,1,1));     // set beats clear
    tbl.push_back(r(0,0,0,0,1, d, 1,1,0));     // clear
    tbl.push_back(r(0,0,0,1,0, d, 0,0,0));     // transfer

    foreach (tbl[i]) begin
      sof = tbl[i].sof; bit_vld = tbl[i].bv; bit_dat = tbl[i].bd;
      word_rdy = tbl[i].rdy; clr_ovr = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_word", i), 32'(word), 32'(tbl[i].e_word));
      chk($sformatf("tbl%0d_vld", i), 32'(word_vld), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_ovr", i), 32'(ovr), 32'(tbl[i].e_ovr));
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_par", i), 32'(par_err), 32'd0);
    end
    sof = 0; bit_vld = 0; clr_ovr = 0; word_rdy = 0;

    // ---- gapped bits with backpressure ----
    d = 8'h3C;
    send_frame(d, 1, ^d);
    chk("gap_word", 32'(word), 32'(d));
    repeat (5) begin
      tick();
      chk("bp_vld", 32'(word_vld), 32'd1);
      chk("bp_word", 32'(word), 32'(d));
    end
    word_rdy = 1'b1;
    tick();
    chk("bp_xfer_vld", 32'(word_vld), 32'd0);
    chk("bp_xfer_busy", 32'(busy), 32'd0);
    word_rdy = 1'b0;

    // ---- abort: 3 bits, then a fresh frame of 0xFF ----
    sof = 1; bit_vld = 1; bit_dat = 0; tick();
    sof = 0; tick(); tick();
    d = 8'hFF;
    send_frame(d, 0, ^d);
    chk("abort_word", 32'(word), 32'hFF);
    chk("abort_ovr", 32'(ovr), 32'd0);
    word_rdy = 1'b1; tick(); word_rdy = 1'b0;

    // ---- back-to-back: new sof on the transfer edge of 0x12 ----
    d = 8'h12;
    send_frame(d, 0, ^d);
    chk("b2b_first", 32'(word), 32'h12);
    word_rdy = 1'b1;
    d2 = 8'h34;
    send_frame(d2, 0, ^d2);
    chk("b2b_word", 32'(word), 32'h34);
    chk("b2b_ovr", 32'(ovr), 32'd0);
    tick();
    word_rdy = 1'b0;

    // ---- parity error: 0xB2 with a wrong parity bit ----
    d = 8'hB2;
    send_frame(d, 0, 1'b1);
    chk("perr_word", 32'(word), 32'hB2);
    chk("perr_flag", 32'(par_err), 32'(PAR));
    word_rdy = 1'b1; tick(); word_rdy = 1'b0;

    // ---- reset mid-frame ----
    sof = 1; bit_vld = 1; bit_dat = 1; tick();
    sof = 0; tick(); tick();
    bit_vld = 0;
    #2 rst = 1'b1;
    #1;
    chk("mrst_word", 32'(word), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_vld", 32'(word_vld), 32'd0);
    @(negedge clk); rst = 1'b0;
    d = 8'hA5;
    word_rdy = 1'b0;
    send_frame(d, 0, ^d);
    chk("mrst_a5", 32'(word), 32'hA5);
    word_rdy = 1'b1; tick(); word_rdy = 1'b0;

    // ---- randomized frames against a frame-level model ----
    exp_ovr = 1'b0;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        // A partial frame that the following sof must abort.
        k = $urandom_range(1, DW-1);
        for (int b = 0; b < k; b++) begin
          sof = (b == 0); bit_vld = 1; bit_dat = 1'($urandom()); tick();
        end
        sof = 0; bit_vld = 0;
      end
      d    = DW'($urandom());
      flip = 1'($urandom());
      send_frame(d, $urandom_range(0, 2), (^d) ^ flip);
      chk("rnd_word", 32'(word), 32'(d));
      chk("rnd_par", 32'(par_err), 32'(PAR ? flip : 1'b0));
      k = $urandom_range(0, 4);
      for (int h = 0; h < k; h++) begin
        sof = ($urandom_range(0, 2) == 0);
        clr_ovr = ($urandom_range(0, 2) == 0);
        bit_vld = 1'($urandom()); bit_dat = 1'($urandom());
        exp_ovr = sof ? 1'b1 : (clr_ovr ? 1'b0 : exp_ovr);
        tick();
        chk("rnd_hold_word", 32'(word), 32'(d));
        chk("rnd_hold_vld", 32'(word_vld), 32'd1);
        chk("rnd_ovr", 32'(ovr), 32'(exp_ovr));
      end
      sof = 0; clr_ovr = 0; bit_vld = 0;
      word_rdy = 1'b1;
      tick();
      chk("rnd_xfer_vld", 32'(word_vld), 32'd0);
      chk("rnd_xfer_busy", 32'(busy), 32'd0);
      word_rdy = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
